// File: rtl/per_port_demux.sv
// per_port_demux
//   Egress demultiplexer. One AXI4-Stream input is steered, packet by packet,
//   to any subset of C_M_NUM_QUEUES output queues. The subset is the one-hot
//   destination field of tuser on the first beat. Packets with an empty mask
//   are swallowed and counted in drop_count.
//
// Ports
//   axi_aclk, axi_reset, sw_rst      clock, synchronous active-high resets
//   s_axis_*                         input stream (tdata/tstrb/tuser/tvalid/tready/tlast)
//   m_axis_*_grp                     per-queue output streams, queue i in slice i;
//                                    payload is shared, only tvalid differs per queue
//   m_axis_tready_grp                per-queue ready
//   drop_count                       count of dropped packets, wraps
//
// state   | meaning
// --------+---------------------------------------------------------------
// SOP     | next accepted beat is the first beat of a packet; mask decoded
// PKT     | inside a delivered packet; beats use the latched pkt_mask
// DROP    | inside a dropped packet; beats are accepted and discarded
module per_port_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_NUM_QUEUES       = 5,
  parameter int C_DST_PORT_POS       = 24
) (
  input  logic                                                axi_aclk,
  input  logic                                                axi_reset,
  input  logic                                                sw_rst,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]                      s_axis_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]                    s_axis_tstrb,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]                     s_axis_tuser,
  input  logic                                                s_axis_tvalid,
  output logic                                                s_axis_tready,
  input  logic                                                s_axis_tlast,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_grp,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_grp,
  output logic [C_M_NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_grp,
  output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tvalid_grp,
  input  logic [C_M_NUM_QUEUES-1:0]                           m_axis_tready_grp,
  output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tlast_grp,
  output logic [31:0]                                         drop_count
);

  localparam int NQ     = C_M_NUM_QUEUES;
  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  localparam logic [1:0] ST_SOP  = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]                          state;
  logic [NQ-1:0]                       pkt_mask;
  logic [NQ-1:0]                       pending;
  logic [NQ-1:0]                       beat_mask;
  logic [NQ-1:0]                       load_mask;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      data_r;
  logic [STRB_W-1:0]                   strb_r;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     user_r;
  logic                                last_r;
  logic                                rst;
  logic                                drain_done;
  logic                                accept;
  logic                                load;
  logic                                drop_sop;

  assign rst        = axi_reset | sw_rst;
  assign beat_mask  = s_axis_tuser[C_DST_PORT_POS +: NQ];

  // The held beat is finished once every queue still owed it takes it now,
  // so a new beat can be accepted in the same cycle the last copy leaves.
  assign drain_done = ((pending & ~m_axis_tready_grp) == '0);

  // DROP never loads the output register, so it need not wait for drain.
  assign s_axis_tready = (state == ST_DROP) ? 1'b1 : drain_done;

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign load_mask = (state == ST_PKT) ? pkt_mask : beat_mask;
  assign load      = accept & ((state == ST_PKT) |
                               ((state == ST_SOP) & (beat_mask != '0)));
  assign drop_sop  = accept & (state == ST_SOP) & (beat_mask == '0);

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state    <= ST_SOP;
      pkt_mask <= '0;
    end else if (accept) begin
      case (state)
        ST_SOP: begin
          if (beat_mask != '0) begin
            pkt_mask <= beat_mask;
            if (!s_axis_tlast) state <= ST_PKT;
          end else if (!s_axis_tlast) begin
            state <= ST_DROP;
          end
        end
        ST_PKT, ST_DROP: begin
          if (s_axis_tlast) state <= ST_SOP;
        end
        default: state <= ST_SOP;
      endcase
    end
  end

  // Shared output register. A load overrides any same-cycle drain because
  // the load only happens once the old beat has fully drained.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      data_r  <= '0;
      strb_r  <= '0;
      user_r  <= '0;
      last_r  <= 1'b0;
      pending <= '0;
    end else if (load) begin
      data_r  <= s_axis_tdata;
      strb_r  <= s_axis_tstrb;
      user_r  <= s_axis_tuser;
      last_r  <= s_axis_tlast;
      pending <= load_mask;
    end else begin
      pending <= pending & ~m_axis_tready_grp;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_sop) begin
      drop_count <= drop_count + 32'd1;
    end
  end

  assign m_axis_tvalid_grp = pending;
  assign m_axis_tdata_grp  = {NQ{data_r}};
  assign m_axis_tstrb_grp  = {NQ{strb_r}};
  assign m_axis_tuser_grp  = {NQ{user_r}};
  assign m_axis_tlast_grp  = {NQ{last_r}};

endmodule
